// File: rtl/sum6_accumulator.sv
// -----------------------------------------------------------------------------
// sum6_accumulator
//   Accumulates bursts of 6-bit unsigned sums from the upstream three-operand
//   adder into a saturating ACC_W-bit total. The result is presented on a
//   held ready/valid output.
//   FSM: IDLE -> ACCUM (start) -> HOLD (last beat) -> IDLE (result accepted).
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   start_i      burst request, sampled in IDLE only
//   len_i        burst length, sampled with start_i (0 = 2^CNT_W samples)
//   in_valid_i   in_sum_i is valid
//   in_sum_i     unsigned 6-bit sum from the adder
//   in_ready_o   a beat is accepted this cycle (in_valid_i & in_ready_o)
//   out_valid_o  out_acc_o / out_ovf_o hold a finished burst
//   out_acc_o    accumulated total
//   out_ovf_o    burst saturated
//   out_ready_i  consumer takes the result
//   busy_o       high in ACCUM or HOLD
// -----------------------------------------------------------------------------
module sum6_accumulator #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             in_valid_i,
   input  logic [5:0]       in_sum_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [ACC_W-1:0] out_acc_o,
   output logic             out_ovf_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   // Remaining count is one bit wider so len=0 can encode 2^CNT_W samples.
   localparam logic [CNT_W:0] REM_ONE  = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] REM_FULL = REM_ONE << CNT_W;

   logic [1:0]       state_q, state_d;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, out_valid_q, busy_q;

   logic             beat;
   logic [ACC_W:0]   sum_full;

   assign beat     = in_valid_i && (state_q == S_ACCUM);
   // One extra bit catches the carry out of the accumulator for saturation.
   assign sum_full = {1'b0, acc_q} + {{(ACC_W-5){1'b0}}, in_sum_i};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = (len_i == '0) ? REM_FULL : {1'b0, len_i};
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat) begin
               rem_d = rem_q - REM_ONE;
               // Once saturated, stay pinned at all-ones for the rest of the burst.
               if (ovf_q || sum_full[ACC_W]) begin
                  acc_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = sum_full[ACC_W-1:0];
               end
               if (rem_q == REM_ONE) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so nothing
   // combinational reaches an output port.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= (state_d == S_ACCUM);
         out_valid_q <= (state_d == S_HOLD);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_acc_o   = acc_q;
   assign out_ovf_o   = ovf_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_sum6_accumulator.sv
// Bench for sum6_accumulator: two instances (ACC_W=16 and ACC_W=8) share
// all inputs, so every burst checks both the wide and the saturating width.
module tb_sum6_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, in_valid, out_ready;
   logic [3:0] len;
   logic [5:0] in_sum;

   logic        ir16, ov16, of16, b16;
   logic [15:0] acc16;
   logic        ir8, ov8, of8, b8;
   logic [7:0]  acc8;

   sum6_accumulator #(.ACC_W(16), .CNT_W(4)) u16 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len),
      .in_valid_i(in_valid), .in_sum_i(in_sum), .in_ready_o(ir16),
      .out_valid_o(ov16), .out_acc_o(acc16), .out_ovf_o(of16),
      .out_ready_i(out_ready), .busy_o(b16));

   sum6_accumulator #(.ACC_W(8), .CNT_W(4)) u8 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len),
      .in_valid_i(in_valid), .in_sum_i(in_sum), .in_ready_o(ir8),
      .out_valid_o(ov8), .out_acc_o(acc8), .out_ovf_o(of8),
      .out_ready_i(out_ready), .busy_o(b8));

   int checks = 0;
   int errors = 0;
   int beats  = 0;

   typedef struct {
      int a16; bit o16; int a8; bit o8;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      int len; int v0; int step; bit gap; int hold;
      int a16; bit o16; int a8; bit o8;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard side: sample mid-cycle; a result is taken when the next
   // rising edge sees out_valid & out_ready.
   always @(negedge clk) begin
      #2;
      if (rst_n && in_valid && ir16) beats++;
      if (ov16 && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result got acc %0d expected none", acc16);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("acc16", 32'(acc16), e.a16);
            chk("ovf16", 32'(of16), 32'(e.o16));
            chk("acc8", 32'(acc8), e.a8);
            chk("ovf8", 32'(of8), 32'(e.o8));
            chk("ovalid8", 32'(ov8), 1);
         end
      end
   end

   task automatic run_burst(input vec_t v);
      int n, b0;
      exp_t e;
      n = (v.len == 0) ? 16 : v.len;
      e.a16 = v.a16; e.o16 = v.o16; e.a8 = v.a8; e.o8 = v.o8;
      sbq.push_back(e);
      start = 1'b1; len = 4'(v.len); out_ready = (v.hold == 0);
      @(negedge clk);
      start = 1'b0;
      chk("in_ready_after_start", 32'(ir16), 1);
      chk("busy_after_start", 32'(b16 & b8 & ir8), 1);
      b0 = beats;
      for (int i = 0; i < n; i++) begin
         if (v.gap) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_sum   = 6'((v.v0 + v.step * i) & 63);
         @(negedge clk);
      end
      // in_valid stays high one HOLD cycle: must not count as a beat
      chk("ovalid_after_last", 32'(ov16), 1);
      chk("in_ready_drop", 32'(ir16), 0);
      if (v.hold > 0) begin
         for (int h = 0; h < v.hold; h++) begin
            chk("hold_valid", 32'(ov16), 1);
            chk("hold_acc", 32'(acc16), v.a16);
            start = (h == 3);
            @(negedge clk);
            in_valid = 1'b0;
         end
         start = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ovalid_pulse_end", 32'(ov16), 0);
      chk("idle_after_accept", 32'(b16), 0);
      chk("beat_count", 32'(beats - b0), 32'(n));
      if (v.hold > 0) begin
         @(negedge clk);
         chk("hold_start_ignored", 32'(b16), 0);
      end
   endtask

   initial begin
      vec_t tbl[6];
      tbl[0] = '{len:3, v0:63, step:0,  gap:0, hold:0,  a16:189,  o16:0, a8:189, o8:0};
      tbl[1] = '{len:0, v0:0,  step:1,  gap:1, hold:0,  a16:120,  o16:0, a8:120, o8:0};
      tbl[2] = '{len:5, v0:63, step:0,  gap:0, hold:0,  a16:315,  o16:0, a8:255, o8:1};
      tbl[3] = '{len:2, v0:10, step:10, gap:0, hold:0,  a16:30,   o16:0, a8:30,  o8:0};
      tbl[4] = '{len:1, v0:42, step:0,  gap:0, hold:10, a16:42,   o16:0, a8:42,  o8:0};
      tbl[5] = '{len:0, v0:63, step:0,  gap:0, hold:0,  a16:1008, o16:0, a8:255, o8:1};

      // Reset with start and in_valid asserted
      rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_sum = 6'd63;
      len = 4'd3; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(ir16 | ir8), 0);
      chk("rst_out_valid", 32'(ov16 | ov8), 0);
      chk("rst_acc16", 32'(acc16), 0);
      chk("rst_acc8", 32'(acc8), 0);
      chk("rst_ovf", 32'(of16 | of8), 0);
      chk("rst_busy", 32'(b16 | b8), 0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", 32'(b16), 0);

      for (int k = 0; k < 6; k++) run_burst(tbl[k]);

      // Reset mid-burst: partial sum must never be presented
      start = 1'b1; len = 4'd8;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sum = 6'd5;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("mid_busy", 32'(b16), 1);
      chk("mid_acc", 32'(acc16), 20);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", 32'(b16 | ir16), 0);
      chk("mid_rst_valid", 32'(ov16 | ov8), 0);
      chk("mid_rst_acc", 32'(acc16), 0);
      @(negedge clk);
      chk("mid_rst_idle", 32'(b16), 0);
      begin
         vec_t v;
         v = '{len:1, v0:7, step:0, gap:0, hold:0, a16:7, o16:0, a8:7, o8:0};
         run_burst(v);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
